// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the main-memory arbiter
package mem_arb_pkg;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  localparam int STARVE_LIMIT = 4;
  localparam int MEM_ADDR_WIDTH = 14;

  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// rtl/mem_arb_starve_cnt.sv - saturating wait counter for the low-priority port
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT
) (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam int W = starve_cnt_width(LIMIT);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt;

  // Any grant or a withdrawn request restarts the wait; otherwise count up and hold at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != LIMIT_V) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fixed-priority arbiter for the single-ported main memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = mem_arb_pkg::STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  p0_req,
  input  logic                  p0_write,
  input  logic [3:0]            p0_wmask,
  input  logic [31:0]           p0_wdata,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [31:0]           p0_rdata,

  input  logic                  p1_req,
  input  logic                  p1_write,
  input  logic [3:0]            p1_wmask,
  input  logic [31:0]           p1_wdata,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [31:0]           p1_rdata,

  output logic                  m_write,
  output logic [3:0]            m_wmask,
  output logic [31:0]           m_wdata,
  output logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [31:0]           m_rdata
);

  logic at_limit;
  logic sel;
  logic rd0_q;
  logic rd1_q;

  mem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .req      (p1_req),
    .gnt      (p1_gnt),
    .at_limit (at_limit)
  );

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rstn) begin
      if (at_limit && p1_req) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  assign sel = p1_gnt ? ARB_P1 : ARB_P0;

  always_comb begin
    m_addr  = p0_addr;
    m_wdata = p0_wdata;
    m_wmask = p0_wmask;
    if (sel == ARB_P1) begin
      m_addr  = p1_addr;
      m_wdata = p1_wdata;
      m_wmask = p1_wmask;
    end
  end

  assign m_write = (p0_gnt & p0_write) | (p1_gnt & p1_write);

  // Tag each accepted read with its port so the data one cycle later is routed back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd0_q <= 1'b0;
      rd1_q <= 1'b0;
    end else begin
      rd0_q <= p0_gnt & ~p0_write;
      rd1_q <= p1_gnt & ~p1_write;
    end
  end

  assign p0_rvalid = rd0_q;
  assign p1_rvalid = rd1_q;
  assign p0_rdata  = rd0_q ? m_rdata : 32'h0;
  assign p1_rdata  = rd1_q ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 14;

  logic          clk;
  logic          rstn;
  logic          p0_req, p0_write, p0_gnt, p0_rvalid;
  logic [3:0]    p0_wmask;
  logic [31:0]   p0_wdata, p0_rdata;
  logic [AW-1:0] p0_addr;
  logic          p1_req, p1_write, p1_gnt, p1_rvalid;
  logic [3:0]    p1_wmask;
  logic [31:0]   p1_wdata, p1_rdata;
  logic [AW-1:0] p1_addr;
  logic          m_write;
  logic [3:0]    m_wmask;
  logic [31:0]   m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  logic [31:0]   mem [0:(1<<AW)-1];

  int n_pass;
  int n_fail;
  int n_total;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .p0_req    (p0_req),
    .p0_write  (p0_write),
    .p0_wmask  (p0_wmask),
    .p0_wdata  (p0_wdata),
    .p0_addr   (p0_addr),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_write  (p1_write),
    .p1_wmask  (p1_wmask),
    .p1_wdata  (p1_wdata),
    .p1_addr   (p1_addr),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .m_write   (m_write),
    .m_wmask   (m_wmask),
    .m_wdata   (m_wdata),
    .m_addr    (m_addr),
    .m_rdata   (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported synchronous memory model with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (m_write) begin
      for (int b = 0; b < 4; b++) begin
        if (m_wmask[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end
    end
    m_rdata <= mem[m_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic prev0, prev1;

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    mem[14'h0010] = 32'hDEADBEEF;
    mem[14'h0020] = 32'h11223344;
    m_rdata  = 32'h0;
    rstn     = 1'b0;
    p0_req = 1'b1; p0_write = 1'b1; p0_wmask = 4'hF; p0_wdata = 32'hCAFE0000; p0_addr = 14'h0010;
    p1_req = 1'b0; p1_write = 1'b0; p1_wmask = 4'h0; p1_wdata = 32'h0;       p1_addr = 14'h0020;

    // reset holds grants and strobes low
    @(negedge clk); #1;
    check("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
    check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);

    // first cycle after release: p0 read 0x0010
    @(negedge clk);
    rstn = 1'b1; p0_write = 1'b0; #1;
    check("rd0_gnt", {31'b0, p0_gnt}, 32'd1);
    check("rd0_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    next_cycle(); #1;
    check("rd0_rvalid", {31'b0, p0_rvalid}, 32'd1);
    check("rd0_rdata", p0_rdata, 32'hDEADBEEF);
    check("rd0_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    check("rd0_p1_rdata", p1_rdata, 32'h0);
    p0_req = 1'b0;
    next_cycle();

    // both request every cycle: p1 forced every fifth cycle
    p0_req = 1'b1; p1_req = 1'b1; p1_write = 1'b0;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("starve_p1_gnt_%0d", i), {31'b0, p1_gnt}, {31'b0, (i % 5) == 4});
      check($sformatf("starve_p0_gnt_%0d", i), {31'b0, p0_gnt}, {31'b0, (i % 5) != 4});
      check($sformatf("starve_p0_rv_%0d", i), {31'b0, p0_rvalid}, {31'b0, prev0});
      check($sformatf("starve_p1_rd_%0d", i), p1_rdata, prev1 ? 32'h11223344 : 32'h0);
      prev0 = ((i % 5) != 4);
      prev1 = ((i % 5) == 4);
      next_cycle();
    end
    p0_req = 1'b0; p1_req = 1'b0; p0_addr = 14'h0055; #1;
    check("idle_m_addr", {18'b0, m_addr}, 32'h55);
    check("idle_m_write", {31'b0, m_write}, 32'd0);
    check("tail_p1_rvalid", {31'b0, p1_rvalid}, {31'b0, prev1});
    check("tail_p1_rdata", p1_rdata, 32'h11223344);
    next_cycle();

    // p1 partial write then readback
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 14'h0020; p1_wmask = 4'b0100; p1_wdata = 32'h00AB0000; #1;
    check("wr_p1_gnt", {31'b0, p1_gnt}, 32'd1);
    check("wr_m_write", {31'b0, m_write}, 32'd1);
    check("wr_m_wmask", {28'b0, m_wmask}, 32'h4);
    check("wr_m_addr", {18'b0, m_addr}, 32'h20);
    next_cycle();
    p1_write = 1'b0; #1;
    check("wr_no_rvalid", {31'b0, p1_rvalid}, 32'd0);
    check("rb_m_write", {31'b0, m_write}, 32'd0);
    next_cycle();
    p1_req = 1'b0; p0_req = 1'b1; p0_write = 1'b0; p0_addr = 14'h0010; #1;
    check("rb_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
    check("rb_p1_rdata", p1_rdata, 32'h11AB3344);

    // alternating ports: data follows the issuer
    check("alt_a_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    next_cycle();
    p0_req = 1'b0; p1_req = 1'b1; #1;
    check("alt_b_p1_gnt", {31'b0, p1_gnt}, 32'd1);
    check("alt_b_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("alt_b_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    next_cycle();
    p1_req = 1'b0; p0_req = 1'b1; p0_addr = 14'h0020; #1;
    check("alt_c_p1_rdata", p1_rdata, 32'h11AB3344);
    check("alt_c_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
    next_cycle();
    p0_req = 1'b0; #1;
    check("alt_d_p0_rdata", p0_rdata, 32'h11AB3344);
    check("alt_d_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    next_cycle();

    // p1 withdraws at count 3: wait restarts from zero
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 14'h0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("drop_pre_p1_gnt_%0d", i), {31'b0, p1_gnt}, 32'd0);
      next_cycle();
    end
    p1_req = 1'b0; #1;
    check("drop_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    next_cycle();
    p1_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("drop_post_p1_gnt_%0d", i), {31'b0, p1_gnt}, {31'b0, i == 4});
      next_cycle();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    next_cycle();

    // reset right after a p0 read grant drops the pending rvalid
    p0_req = 1'b1; p0_addr = 14'h0010; #1;
    check("rr_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0; p1_req = 1'b1; p1_write = 1'b1;
    @(negedge clk); #1;
    check("rr_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
    check("rr_p0_gnt_rst", {31'b0, p0_gnt}, 32'd0);
    check("rr_p1_gnt_rst", {31'b0, p1_gnt}, 32'd0);
    check("rr_m_write_rst", {31'b0, m_write}, 32'd0);
    next_cycle();
    rstn = 1'b1; p1_req = 1'b0; p1_write = 1'b0; #1;
    check("rr_first_gnt", {31'b0, p0_gnt}, 32'd1);
    next_cycle(); #1;
    check("rr_rvalid", {31'b0, p0_rvalid}, 32'd1);
    check("rr_rdata", p0_rdata, 32'hDEADBEEF);
    p0_req = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported 64 KiB main memory (SPRAM, one-cycle read latency) between the pipeline data port (port 0) and a secondary master such as a DMA or UART loader (port 1). Port 0 has fixed priority. A starvation counter forces a port-1 grant after a bounded wait. The block routes read data back to the requester that issued the read. It sits between the requesters and the main-memory instance in the top-level wrapper, in place of the direct pipeline-to-memory wiring.

## Interface
- ADDR_WIDTH, 14: word-address width of the memory (16 K words = 64 KiB).
- STARVE_LIMIT, 4: consecutive cycles port 1 may wait before a forced grant. Must be ≥1.

- clk  input  1  system clock, all state on rising edge
- rstn  input  1  reset, asynchronous, active-low
- p0_req  input  1  port 0 requests an access this cycle
- p0_write  input  1  1 = write, 0 = read
- p0_wmask  input  4  byte-write enables (bit n = byte n)
- p0_wdata  input  32  write data
- p0_addr  input  ADDR_WIDTH  word address
- p0_gnt  output  1  access accepted this cycle
- p0_rvalid  output  1  read data for port 0 valid this cycle
- p0_rdata  output  32  read data
- p1_req, p1_write, p1_wmask, p1_wdata, p1_addr  input  1/1/4/32/ADDR_WIDTH  same meaning as port 0
- p1_gnt, p1_rvalid, p1_rdata  output  1/1/32  same meaning as port 0
- m_write  output  1  memory write strobe
- m_wmask  output  4  memory byte enables
- m_wdata  output  32  memory write data
- m_addr  output  ADDR_WIDTH  memory word address
- m_rdata  input  32  memory read data, valid one cycle after the address

## Operation
- Grant is combinational in the request cycle.
  - Default: p0_gnt = p0_req; p1_gnt = p1_req & ~p0_req.
  - Forced: when starve_cnt == STARVE_LIMIT and p1_req = 1, then p1_gnt = 1 and p0_gnt = 0, even if p0_req = 1.
  - At most one gnt is high per cycle.
- Memory mux: m_addr, m_wdata and m_wmask come from the granted port.
  - With no grant, they carry port-0 values.
  - m_write = granted port's write & gnt. It is never high without a grant.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments each cycle p1_req = 1 and p1_gnt = 0.
  - Clears when p1_gnt = 1 or p1_req = 0.
  - Saturates at STARVE_LIMIT; it never wraps.
- Read return: the registered flags rd0_q and rd1_q capture (gnt & ~write) per port.
  - Next cycle: pN_rvalid = rdN_q, and pN_rdata = m_rdata when rdN_q = 1.
  - pN_rdata = 0 when rdN_q = 0.
- Writes never produce an rvalid.
- Requesters hold req and all request fields stable until gnt is seen. The arbiter does not latch a request that has not been granted.
- Reset: starve_cnt = 0, rd0_q = 0, rd1_q = 0.
  - While rstn = 0, both gnt and m_write are forced to 0 and both rvalid are 0.
  - A read accepted in the cycle before reset asserts is dropped and gets no rvalid.

## Timing
- Grant latency 0 cycles; read-data latency 1 cycle after grant; write takes effect at the grant edge.
- Back-to-back accesses are allowed every cycle on either port, with full throughput of one access per cycle.
- Worst-case port-1 wait is STARVE_LIMIT cycles. The port-0 stall caused by a forced grant is one cycle.
- Simultaneous read grant in cycle N and grant to the other port in cycle N+1: the rvalid for N appears in N+1 on the correct port, independent of the N+1 grant.
- Reset deassertion: the first grant is possible in the first cycle rstn = 1.

## Structure
- Shared package mem_arb_pkg:
  - port index constants ARB_P0 = 0, ARB_P1 = 1.
  - STARVE_LIMIT default.
- Sub-module mem_arb_starve_cnt: saturating counter with inputs req and gnt, output at_limit, parameter LIMIT.
- Grant logic, memory mux and read-return flags stay in mem_arbiter.

## Test plan
- Only p0 read addr 0x0010, memory word 0xDEADBEEF: p0_gnt same cycle, p0_rvalid = 1 with p0_rdata = 0xDEADBEEF next cycle, p1_rvalid = 0.
- Both req every cycle, STARVE_LIMIT = 4: p0 granted cycles 0–3, p1 granted cycle 4, p0 cycle 5, and the pattern repeats with period 5.
- p1 write addr 0x0020, wmask 0b0100, wdata 0x00AB0000, then p1 read of the same address: only byte 2 changes, read returns it, no rvalid on the write.
- Alternating grants p0 read / p1 read on consecutive cycles: each rvalid lands on the issuing port one cycle later, never both high.
- p1_req drops at starve_cnt = 3, then reasserts: counter restarts from 0 and the forced grant comes 4 cycles later.
- rstn asserted in the cycle after a p0 read grant: p0_rvalid stays 0 and all gnt = 0 during reset; after release, normal grants resume in the first cycle.
